// File: rtl/prefetch_seq_ctrl.sv
// -----------------------------------------------------------------------------
// prefetch_seq_ctrl
//
// Sequencer for the prefetch halfword fetch buffer. Decides when to translate
// and fetch the next 32-bit word through the MMU and icache, tracks how many
// halfwords the buffer holds and the PC of the buffer head, and drops a stale
// icache response that was in flight when a redirect arrived.
//
// Optional build macro: PREFETCH_PERF_CNT_EN
//   When defined, adds saturating stall/discard/fill counters as outputs.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   redirect_i/_pc_i   clear buffer and restart fetch at a halfword-aligned PC
//   consume_i/_size_i  IF takes a 16-bit (size 0) or 32-bit (size 1) instr
//   consume_ok_o       consume accepted this cycle
//   avail_hw_o         valid halfwords in the buffer
//   head_pc_o          PC of buffer head; head_misalign_o = head_pc_o[1]
//   flush_o            datapath clears buffer (copy of redirect_i)
//   fill_o             datapath writes the icache word this cycle
//   fill_hi_only_o     with fill_o: only the upper halfword is valid
//   mmu_req_o/_vaddr_o translation request, word-aligned vaddr
//   mmu_hit_i/_paddr_i translation result
//   ic_req_o/_addr_o   icache request and latched physical address
//   ic_ack_i           icache data valid
//   stall_cnt_o, discard_cnt_o, fill_cnt_o   (PREFETCH_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module prefetch_seq_ctrl #(
  parameter int              XLEN      = 32,
  parameter int              BUF_WORDS = 2,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            consume_i,
  input  logic            consume_size_i,
  output logic            consume_ok_o,
  output logic [2:0]      avail_hw_o,
  output logic [XLEN-1:0] head_pc_o,
  output logic            head_misalign_o,
`ifdef PREFETCH_PERF_CNT_EN
  output logic [31:0]     stall_cnt_o,
  output logic [15:0]     discard_cnt_o,
  output logic [31:0]     fill_cnt_o,
`endif
  output logic            flush_o,
  output logic            fill_o,
  output logic            fill_hi_only_o,
  output logic            mmu_req_o,
  output logic [XLEN-1:0] mmu_vaddr_o,
  input  logic            mmu_hit_i,
  input  logic [XLEN-1:0] mmu_paddr_i,
  output logic            ic_req_o,
  output logic [XLEN-1:0] ic_addr_o,
  input  logic            ic_ack_i
);

  typedef enum logic [1:0] {IDLE, XLATE, WAIT_ACK, DISCARD} state_t;

  // A new word is only requested when two halfwords are free, so a fill can
  // never overflow the buffer even if nothing is consumed meanwhile.
  localparam logic [2:0] FETCH_LIMIT = 3'(2 * BUF_WORDS - 2);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_fetch_addr;
  logic [XLEN-1:0] r_head_pc;
  logic [2:0]      r_hw_cnt;
  logic            r_first_hi;
  logic [XLEN-1:0] r_ic_addr;

  logic            w_consume_ok;
  logic [2:0]      w_need;
  logic [2:0]      w_cons_amt;
  logic [2:0]      w_fill_amt;
  logic [XLEN-1:0] w_head_inc;
  logic            w_ack_wait;
  logic            w_fill;
  logic            w_hit;
  logic            w_drop_ack;

  // NOTE: every signal written here gets a default first so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_need       = consume_size_i ? 3'd2 : 3'd1;
    w_head_inc   = consume_size_i ? XLEN'(4) : XLEN'(2);
    // Availability is judged on the registered count: a fill landing this
    // cycle cannot satisfy a consume in the same cycle.
    w_consume_ok = consume_i && !redirect_i && (r_hw_cnt >= w_need);
    w_cons_amt   = w_consume_ok ? w_need : 3'd0;
    w_ack_wait   = (r_state == WAIT_ACK) && ic_ack_i;
    w_fill       = w_ack_wait && !redirect_i;
    w_fill_amt   = w_fill ? (r_first_hi ? 3'd1 : 3'd2) : 3'd0;
    w_hit        = (r_state == XLATE) && mmu_hit_i && !redirect_i;
    w_drop_ack   = ((r_state == DISCARD) && ic_ack_i) || (w_ack_wait && redirect_i);

    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (!redirect_i && (r_hw_cnt <= FETCH_LIMIT)) w_state_nxt = XLATE;
      XLATE:    if (redirect_i) w_state_nxt = IDLE;
                else if (mmu_hit_i) w_state_nxt = WAIT_ACK;
      WAIT_ACK: if (redirect_i) w_state_nxt = ic_ack_i ? IDLE : DISCARD;
                else if (ic_ack_i) w_state_nxt = IDLE;
      // The stale response is the only one outstanding; once it arrives it is
      // retired even if a further redirect coincides, so fetch cannot hang.
      DISCARD:  if (ic_ack_i) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_fetch_addr <= RESET_PC;
      r_head_pc    <= RESET_PC;
      r_hw_cnt     <= '0;
      r_first_hi   <= RESET_PC[1];
      r_ic_addr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_i) begin
        r_hw_cnt     <= '0;
        r_head_pc    <= redirect_pc_i;
        r_fetch_addr <= {redirect_pc_i[XLEN-1:2], 2'b00};
        r_first_hi   <= redirect_pc_i[1];
      end else begin
        r_hw_cnt <= r_hw_cnt + w_fill_amt - w_cons_amt;
        if (w_consume_ok) r_head_pc <= r_head_pc + w_head_inc;
        if (w_fill) begin
          r_first_hi   <= 1'b0;
          r_fetch_addr <= r_fetch_addr + XLEN'(4);
        end
        if (w_hit) r_ic_addr <= mmu_paddr_i;
      end
    end
  end

  assign consume_ok_o    = w_consume_ok;
  assign avail_hw_o      = r_hw_cnt;
  assign head_pc_o       = r_head_pc;
  assign head_misalign_o = r_head_pc[1];
  assign flush_o         = redirect_i;
  assign fill_o          = w_fill;
  assign fill_hi_only_o  = w_fill && r_first_hi;
  assign mmu_req_o       = (r_state == XLATE);
  assign mmu_vaddr_o     = {r_fetch_addr[XLEN-1:2], 2'b00};
  assign ic_req_o        = (r_state == WAIT_ACK) || (r_state == DISCARD);
  assign ic_addr_o       = r_ic_addr;

`ifdef PREFETCH_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [15:0] r_discard_cnt;
  logic [31:0] r_fill_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt   <= '0;
      r_discard_cnt <= '0;
      r_fill_cnt    <= '0;
    end else begin
      if (consume_i && !w_consume_ok && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_drop_ack && (r_discard_cnt != '1))
        r_discard_cnt <= r_discard_cnt + 16'd1;
      if (w_fill && (r_fill_cnt != '1))
        r_fill_cnt <= r_fill_cnt + 32'd1;
    end
  end

  assign stall_cnt_o   = r_stall_cnt;
  assign discard_cnt_o = r_discard_cnt;
  assign fill_cnt_o    = r_fill_cnt;
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop_ack;
`endif

endmodule

// File: tb/tb_prefetch_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prefetch_seq_ctrl
//
// Self-checking bench for prefetch_seq_ctrl. Expected fetch addresses and fill
// kinds are queued as each scenario sets up its stimulus; the cycle task pops
// and compares them whenever the DUT hands over a translation or a fill.
// -----------------------------------------------------------------------------
module tb_prefetch_seq_ctrl;

  localparam int          XLEN      = 32;
  localparam logic [31:0] PADDR_XOR = 32'h4000_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            redirect_i = 1'b0;
  logic [XLEN-1:0] redirect_pc_i = '0;
  logic            consume_i = 1'b0;
  logic            consume_size_i = 1'b0;
  logic            consume_ok_o;
  logic [2:0]      avail_hw_o;
  logic [XLEN-1:0] head_pc_o;
  logic            head_misalign_o;
  logic            flush_o;
  logic            fill_o;
  logic            fill_hi_only_o;
  logic            mmu_req_o;
  logic [XLEN-1:0] mmu_vaddr_o;
  logic            mmu_hit_i = 1'b0;
  logic [XLEN-1:0] mmu_paddr_i = '0;
  logic            ic_req_o;
  logic [XLEN-1:0] ic_addr_o;
  logic            ic_ack_i = 1'b0;
`ifdef PREFETCH_PERF_CNT_EN
  logic [31:0]     stall_cnt_o;
  logic [15:0]     discard_cnt_o;
  logic [31:0]     fill_cnt_o;
`endif

  prefetch_seq_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .consume_i       (consume_i),
    .consume_size_i  (consume_size_i),
    .consume_ok_o    (consume_ok_o),
    .avail_hw_o      (avail_hw_o),
    .head_pc_o       (head_pc_o),
    .head_misalign_o (head_misalign_o),
`ifdef PREFETCH_PERF_CNT_EN
    .stall_cnt_o     (stall_cnt_o),
    .discard_cnt_o   (discard_cnt_o),
    .fill_cnt_o      (fill_cnt_o),
`endif
    .flush_o         (flush_o),
    .fill_o          (fill_o),
    .fill_hi_only_o  (fill_hi_only_o),
    .mmu_req_o       (mmu_req_o),
    .mmu_vaddr_o     (mmu_vaddr_o),
    .mmu_hit_i       (mmu_hit_i),
    .mmu_paddr_i     (mmu_paddr_i),
    .ic_req_o        (ic_req_o),
    .ic_addr_o       (ic_addr_o),
    .ic_ack_i        (ic_ack_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_fill_exp = 0;

  logic [XLEN-1:0] q_vaddr[$];
  logic            q_fill_hi[$];
  logic [XLEN-1:0] exp_paddr = '0;

  // Responder controls and per-cycle samples.
  logic hit_en   = 1'b1;
  logic auto_ack = 1'b1;
  logic man_ack  = 1'b0;
  logic            s_fill, s_consume_ok, s_flush, s_ic_req, s_mmu_req;
  logic [XLEN-1:0] s_vaddr;

  task automatic push_fetch(input logic [XLEN-1:0] vaddr, input logic hi_only);
    q_vaddr.push_back(vaddr);
    q_fill_hi.push_back(hi_only);
    n_fill_exp++;
  endtask

  // One clock: responders drive at the falling edge, outputs are sampled 1ns
  // later, scoreboard entries are popped, then time moves past the rising edge.
  task automatic cycle();
    logic [XLEN-1:0] ev;
    logic            eh;
    @(negedge clk);
    mmu_hit_i   = hit_en;
    mmu_paddr_i = mmu_vaddr_o ^ PADDR_XOR;
    ic_ack_i    = (auto_ack && ic_req_o) || man_ack;
    #1;
    s_fill       = fill_o;
    s_consume_ok = consume_ok_o;
    s_flush      = flush_o;
    s_ic_req     = ic_req_o;
    s_mmu_req    = mmu_req_o;
    s_vaddr      = mmu_vaddr_o;
    if (mmu_req_o && mmu_hit_i) begin
      checks++;
      if (q_vaddr.size() == 0) begin
        errors++;
        $display("FAIL mmu_vaddr unexpected request got %h", mmu_vaddr_o);
      end else begin
        ev = q_vaddr.pop_front();
        if (mmu_vaddr_o !== ev) begin
          errors++;
          $display("FAIL mmu_vaddr got %h expected %h", mmu_vaddr_o, ev);
        end
      end
      exp_paddr = mmu_paddr_i;
    end
    if (fill_o) begin
      checks++;
      if (q_fill_hi.size() == 0) begin
        errors++;
        $display("FAIL fill unexpected fill_o=1 expected 0");
      end else begin
        eh = q_fill_hi.pop_front();
        if (fill_hi_only_o !== eh) begin
          errors++;
          $display("FAIL fill_hi_only got %b expected %b", fill_hi_only_o, eh);
        end
      end
    end
    if (ic_req_o) begin
      checks++;
      if (ic_addr_o !== exp_paddr) begin
        errors++;
        $display("FAIL ic_addr got %h expected %h", ic_addr_o, exp_paddr);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name, input logic [2:0] avail,
                             input logic [XLEN-1:0] head);
    checks++;
    if (avail_hw_o !== avail || head_pc_o !== head || head_misalign_o !== head[1]) begin
      errors++;
      $display("FAIL %s avail/head/mis got %0d/%h/%b expected %0d/%h/%b", name,
               avail_hw_o, head_pc_o, head_misalign_o, avail, head, head[1]);
    end
    checks++;
    if (q_vaddr.size() != 0 || q_fill_hi.size() != 0) begin
      errors++;
      $display("FAIL %s pending fetches got %0d expected 0", name, q_vaddr.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (avail_hw_o !== 3'd0 || head_pc_o !== 32'h8000_0000 || mmu_req_o !== 1'b0 ||
        ic_req_o !== 1'b0 || fill_o !== 1'b0 || ic_addr_o !== '0 || head_misalign_o !== 1'b0) begin
      errors++;
      $display("FAIL reset got avail=%0d head=%h mmu=%b ic=%b fill=%b icaddr=%h expected 0/80000000/0/0/0/0",
               avail_hw_o, head_pc_o, mmu_req_o, ic_req_o, fill_o, ic_addr_o);
    end
  endtask

  task automatic test_fill_to_full();
    int extra_req = 0;
    push_fetch(32'h8000_0000, 1'b0);
    push_fetch(32'h8000_0004, 1'b0);
    rst = 1'b0;
    repeat (7) cycle();
    repeat (5) begin
      cycle();
      if (s_mmu_req) extra_req++;
    end
    checks++;
    if (extra_req != 0) begin
      errors++;
      $display("FAIL full_stall mmu_req cycles got %0d expected 0", extra_req);
    end
    check_state("fill_to_full", 3'd4, 32'h8000_0000);
  endtask

  task automatic test_consume();
    push_fetch(32'h8000_0008, 1'b0);
    consume_i = 1'b1; consume_size_i = 1'b1;
    cycle();
    checks++;
    if (s_consume_ok !== 1'b1 || avail_hw_o !== 3'd2 || head_pc_o !== 32'h8000_0004) begin
      errors++;
      $display("FAIL consume32 got ok=%b avail=%0d head=%h expected 1/2/80000004",
               s_consume_ok, avail_hw_o, head_pc_o);
    end
    consume_size_i = 1'b0;
    cycle();
    consume_i = 1'b0;
    checks++;
    if (s_consume_ok !== 1'b1 || avail_hw_o !== 3'd1 || head_pc_o !== 32'h8000_0006) begin
      errors++;
      $display("FAIL consume16 got ok=%b avail=%0d head=%h expected 1/1/80000006",
               s_consume_ok, avail_hw_o, head_pc_o);
    end
    repeat (6) cycle();
    check_state("consume_refill", 3'd3, 32'h8000_0006);
  endtask

  task automatic test_redirect_misalign();
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0102;
    cycle();
    redirect_i = 1'b0;
    checks++;
    if (s_flush !== 1'b1) begin
      errors++;
      $display("FAIL redirect_flush got %b expected 1", s_flush);
    end
    push_fetch(32'h8000_0100, 1'b1);
    push_fetch(32'h8000_0104, 1'b0);
    repeat (3) cycle();
    checks++;
    if (avail_hw_o !== 3'd1) begin
      errors++;
      $display("FAIL redirect_first_fill avail got %0d expected 1", avail_hw_o);
    end
    repeat (4) cycle();
    check_state("redirect_misalign", 3'd3, 32'h8000_0102);
  endtask

  task automatic test_redirect_discard();
    consume_i = 1'b1; consume_size_i = 1'b0;
    auto_ack = 1'b0;
    cycle();
    consume_i = 1'b0;
    q_vaddr.push_back(32'h8000_0108);
    repeat (2) cycle();
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0200;
    cycle();
    redirect_i = 1'b0;
    repeat (2) begin
      cycle();
      checks++;
      if (s_ic_req !== 1'b1) begin
        errors++;
        $display("FAIL discard_ic_req got %b expected 1", s_ic_req);
      end
    end
    man_ack = 1'b1;
    cycle();
    man_ack = 1'b0;
    checks++;
    if (s_fill !== 1'b0) begin
      errors++;
      $display("FAIL discard_fill got %b expected 0", s_fill);
    end
`ifdef PREFETCH_PERF_CNT_EN
    checks++;
    if (discard_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL discard_cnt got %0d expected 1", discard_cnt_o);
    end
`endif
    push_fetch(32'h8000_0200, 1'b0);
    push_fetch(32'h8000_0204, 1'b0);
    auto_ack = 1'b1;
    repeat (8) cycle();
    check_state("redirect_discard", 3'd4, 32'h8000_0200);
  endtask

  task automatic test_fill_consume_same();
    auto_ack = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0300;
    cycle();
    redirect_i = 1'b0;
    push_fetch(32'h8000_0300, 1'b0);
    repeat (2) cycle();
    man_ack = 1'b1;
    cycle();
    man_ack = 1'b0;
    push_fetch(32'h8000_0304, 1'b0);
    consume_i = 1'b1; consume_size_i = 1'b0;
    cycle();
    consume_i = 1'b0;
    cycle();
    man_ack = 1'b1; consume_i = 1'b1; consume_size_i = 1'b1;
    cycle();
    man_ack = 1'b0;
    checks++;
    if (s_consume_ok !== 1'b0 || s_fill !== 1'b1 || avail_hw_o !== 3'd3) begin
      errors++;
      $display("FAIL fill_consume_same got ok=%b fill=%b avail=%0d expected 0/1/3",
               s_consume_ok, s_fill, avail_hw_o);
    end
    hit_en = 1'b0;
    cycle();
    consume_i = 1'b0;
    checks++;
    if (s_consume_ok !== 1'b1) begin
      errors++;
      $display("FAIL consume_retry ok got %b expected 1", s_consume_ok);
    end
    check_state("consume_retry", 3'd1, 32'h8000_0306);
  endtask

  task automatic test_mmu_stall();
    cycle();
    repeat (5) begin
      cycle();
      checks++;
      if (s_mmu_req !== 1'b1 || s_vaddr !== 32'h8000_0308 || s_ic_req !== 1'b0) begin
        errors++;
        $display("FAIL mmu_stall got req=%b vaddr=%h ic_req=%b expected 1/80000308/0",
                 s_mmu_req, s_vaddr, s_ic_req);
      end
    end
    push_fetch(32'h8000_0308, 1'b0);
    hit_en = 1'b1; auto_ack = 1'b1;
    repeat (4) cycle();
    check_state("mmu_stall", 3'd3, 32'h8000_0306);
  endtask

  task automatic test_redirect_with_ack();
    auto_ack = 1'b0;
    consume_i = 1'b1; consume_size_i = 1'b1;
    cycle();
    consume_i = 1'b0;
    q_vaddr.push_back(32'h8000_030C);
    repeat (2) cycle();
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0400;
    man_ack = 1'b1; consume_i = 1'b1; consume_size_i = 1'b0;
    cycle();
    redirect_i = 1'b0; man_ack = 1'b0; consume_i = 1'b0;
    checks++;
    if (s_fill !== 1'b0 || s_consume_ok !== 1'b0 || s_flush !== 1'b1) begin
      errors++;
      $display("FAIL redirect_ack got fill=%b ok=%b flush=%b expected 0/0/1",
               s_fill, s_consume_ok, s_flush);
    end
    check_state("redirect_ack", 3'd0, 32'h8000_0400);
    push_fetch(32'h8000_0400, 1'b0);
    push_fetch(32'h8000_0404, 1'b0);
    auto_ack = 1'b1;
    repeat (8) cycle();
    check_state("after_redirect_ack", 3'd4, 32'h8000_0400);
`ifdef PREFETCH_PERF_CNT_EN
    checks++;
    if (discard_cnt_o !== 16'd2 || stall_cnt_o !== 32'd2 || fill_cnt_o !== 32'(n_fill_exp)) begin
      errors++;
      $display("FAIL perf_cnt got discard=%0d stall=%0d fill=%0d expected 2/2/%0d",
               discard_cnt_o, stall_cnt_o, fill_cnt_o, n_fill_exp);
    end
`endif
  endtask

  task automatic test_reset_mid();
    auto_ack = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0500;
    cycle();
    redirect_i = 1'b0;
    q_vaddr.push_back(32'h8000_0500);
    repeat (2) cycle();
    hit_en = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (ic_req_o !== 1'b0 || avail_hw_o !== 3'd0 || head_pc_o !== 32'h8000_0000 ||
        ic_addr_o !== '0 || mmu_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got ic_req=%b avail=%0d head=%h icaddr=%h mmu=%b expected 0/0/80000000/0/0",
               ic_req_o, avail_hw_o, head_pc_o, ic_addr_o, mmu_req_o);
    end
    cycle();
    rst = 1'b0;
    man_ack = 1'b1;
    cycle();
    man_ack = 1'b0;
    checks++;
    if (s_fill !== 1'b0 || avail_hw_o !== 3'd0) begin
      errors++;
      $display("FAIL late_ack got fill=%b avail=%0d expected 0/0", s_fill, avail_hw_o);
    end
    cycle();
    check_state("reset_mid", 3'd0, 32'h8000_0000);
  endtask

  initial begin
    test_reset();
    test_fill_to_full();
    test_consume();
    test_redirect_misalign();
    test_redirect_discard();
    test_fill_consume_same();
    test_mmu_stall();
    test_redirect_with_ack();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
